// File: rtl/pll_supervisor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_supervisor_pkg
//  Description : Shared state encoding, default parameters and width helpers
//                for the PLL reset/lock supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_supervisor_pkg;

    // Supervisor sequencing states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    localparam int c_DEF_PLL_RST_CYCLES      = 16;
    localparam int c_DEF_LOCK_TIMEOUT_CYCLES = 200000;
    localparam int c_DEF_STABLE_CYCLES       = 1024;
    localparam int c_DEF_MAX_RETRIES         = 3;

    // Counter width sized for the longest phase; never narrower than one bit
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

    // Width of the retry counter; kept at least one bit wide
    function automatic int retry_width(input int max_retries);
        if (max_retries < 1) return 1;
        return $clog2(max_retries + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for single-bit or bundled
//                quasi-static signals crossing into the i_clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give metastability settling time
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Reset and lock sequencer for the clocking PLL. Pulses the
//                PLL reset, waits for lock, qualifies it over a stable window
//                and only then releases the downstream active-low reset.
//                Retries on lock timeout and gives up after MAX_RETRIES.
//                Optional build macro PLL_SUPERVISOR_LOSS_COUNTER_EN enables
//                the saturating lock-loss event counter on o_loss_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = c_DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = c_DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES       = c_DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES         = c_DEF_MAX_RETRIES
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_locked,
    output logic                                o_pll_reset,
    output logic                                o_sys_rst_n,
    output logic                                o_lock_lost,
    output logic                                o_fail,
    output logic [retry_width(MAX_RETRIES)-1:0] o_retry_count,
    output logic [7:0]                          o_loss_count
);

    localparam int c_CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
    localparam int c_RETRY_W = retry_width(MAX_RETRIES);

    localparam logic [c_CNT_W-1:0]   c_RST_LAST  = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_TO_LAST   = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_STB_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = c_RETRY_W'(MAX_RETRIES);
    localparam logic [c_RETRY_W-1:0] c_RETRY_ONE = c_RETRY_W'(1);

    logic                 w_locked_s;

    pll_state_t           r_state;
    pll_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RETRY_W-1:0] w_retry_nxt;
    logic                 w_lost_evt;

    logic                 r_pll_reset;
    logic                 r_sys_rst_n;
    logic                 r_lock_lost;
    logic                 r_fail;

    // Bring the PLL lock flag into the reference clock domain
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_locked),
        .o_q     (w_locked_s)
    );

    // State, phase counter, retry count and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_reset <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
            r_sys_rst_n <= (w_state_nxt == RUN);
            r_lock_lost <= w_lost_evt;
            r_fail      <= (w_state_nxt == FAIL);
        end
    end

    // Next-state, counter and retry decisions; the counter is cleared on
    // every state change so it never needs to wrap
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_retry_nxt = r_retry;
        w_lost_evt  = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry == c_RETRY_MAX) begin
                        w_state_nxt = FAIL;
                    end else begin
                        w_state_nxt = RESET_PLL;
                        w_retry_nxt = r_retry + c_RETRY_ONE;
                    end
                end
            end
            STABLE: begin
                // A dropout here is a glitch, not a failed attempt
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STB_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    w_state_nxt = RESET_PLL;
                    w_lost_evt  = 1'b1;
                end
            end
            FAIL: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef PLL_SUPERVISOR_LOSS_COUNTER_EN
    logic [7:0] r_loss_count;

    // Saturating tally of lock-loss events, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_loss_count <= '0;
        end else if (w_lost_evt && (r_loss_count != 8'hFF)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign o_loss_count = r_loss_count;
`else
    assign o_loss_count = 8'd0;
`endif

    assign o_pll_reset   = r_pll_reset;
    assign o_sys_rst_n   = r_sys_rst_n;
    assign o_lock_lost   = r_lock_lost;
    assign o_fail        = r_fail;
    assign o_retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_supervisor
//  Description : Self-checking bench for pll_lock_supervisor with a
//                phase/elapsed-time reference model and directed timing pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 50;
    localparam int P_STB = 8;
    localparam int P_MAX = 2;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_loss;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .STABLE_CYCLES       (P_STB),
        .MAX_RETRIES         (P_MAX)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_locked      (locked),
        .o_pll_reset   (pll_reset),
        .o_sys_rst_n   (sys_rst_n),
        .o_lock_lost   (lock_lost),
        .o_fail        (fail),
        .o_retry_count (retry_count),
        .o_loss_count  (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase of the bring-up sequence and how many edges it has lasted
    localparam int M_HOLD = 0;   // PLL held in reset
    localparam int M_SEEK = 1;   // waiting for lock
    localparam int M_QUAL = 2;   // lock seen, qualifying
    localparam int M_UP   = 3;   // system released
    localparam int M_DEAD = 4;   // gave up

    int m_phase   = M_HOLD;
    int m_elapsed = 0;
    int m_retries = 0;
    int m_loss    = 0;
    bit m_lost    = 0;
    bit m_valid   = 0;
    bit m_hist[2] = '{0, 0};    // [0] newest sample, [1] two edges old

    always @(posedge clk) begin
        bit ls;
        ls = m_hist[1];
        if (!rst_n) begin
            m_phase   = M_HOLD;
            m_elapsed = 0;
            m_retries = 0;
            m_loss    = 0;
            m_lost    = 0;
            m_hist[0] = 0;
            m_hist[1] = 0;
            m_valid   = 1;
        end else begin
            m_hist[1] = m_hist[0];
            m_hist[0] = locked;
            m_lost    = 0;
            m_elapsed = m_elapsed + 1;
            case (m_phase)
                M_HOLD: if (m_elapsed == P_RST) begin
                    m_phase = M_SEEK; m_elapsed = 0;
                end
                M_SEEK: if (ls) begin
                    m_phase = M_QUAL; m_elapsed = 0;
                end else if (m_elapsed == P_TO) begin
                    m_elapsed = 0;
                    if (m_retries == P_MAX) m_phase = M_DEAD;
                    else begin m_retries++; m_phase = M_HOLD; end
                end
                M_QUAL: if (!ls) begin
                    m_phase = M_SEEK; m_elapsed = 0;
                end else if (m_elapsed == P_STB) begin
                    m_phase = M_UP; m_elapsed = 0; m_retries = 0;
                end
                M_UP: if (!ls) begin
                    m_phase = M_HOLD; m_elapsed = 0; m_lost = 1;
`ifdef PLL_SUPERVISOR_LOSS_COUNTER_EN
                    if (m_loss < 255) m_loss++;
`endif
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pll_reset",   pll_reset,   (m_phase == M_HOLD || m_phase == M_DEAD));
            chk("sys_rst_n",   sys_rst_n,   (m_phase == M_UP));
            chk("lock_lost",   lock_lost,   m_lost);
            chk("fail",        fail,        (m_phase == M_DEAD));
            chk("retry_count", retry_count, m_retries);
            chk("loss_count",  loss_count,  m_loss);
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic outsel(input int sel);
        case (sel)
            0:       return pll_reset;
            1:       return sys_rst_n;
            default: return fail;
        endcase
    endfunction

    task automatic wait_out(input int sel, input logic val, input int limit, input string what);
        int n;
        n = 0;
        while (outsel(sel) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(what, outsel(sel), val);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_pll_reset", pll_reset,   1);
        chk("rst_sys_rst_n", sys_rst_n,   0);
        chk("rst_lock_lost", lock_lost,   0);
        chk("rst_fail",      fail,        0);
        chk("rst_retry",     retry_count, 0);
        chk("rst_loss",      loss_count,  0);
    endtask

    task automatic release_rst(output int t0);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int tr;
        int len;
        rst_n  = 1'b0;
        locked = 1'b0;
`ifdef PLL_SUPERVISOR_LOSS_COUNTER_EN
        exp_loss = 1;
`else
        exp_loss = 0;
`endif

        // Clean bring-up, lock 10 cycles after PLL reset falls
        do_reset();
        release_rst(t0);
        wait_out(0, 1'b0, 20, "clean_pll_fall");
        chk("clean_pll_high_cycles", cyc - t0, 4);
        repeat (10) @(negedge clk);
        locked = 1'b1;
        wait_out(1, 1'b1, 100, "clean_sys_rise");
        chk("clean_release_latency", cyc - t0, 25);
        chk("clean_retry", retry_count, 0);

        // Loss of lock while running
        repeat (5) @(negedge clk);
        tr = cyc;
        locked = 1'b0;
        repeat (2) @(negedge clk);
        chk("loss_sys_still_up", sys_rst_n, 1);
        @(negedge clk);
        chk("loss_cycle", cyc - tr, 3);
        chk("loss_sys_low", sys_rst_n, 0);
        chk("loss_pulse", lock_lost, 1);
        chk("loss_pll_rise", pll_reset, 1);
        chk("loss_count", loss_count, exp_loss);
        @(negedge clk);
        chk("loss_pulse_end", lock_lost, 0);
        repeat (2) @(negedge clk);
        chk("loss_pll_last", pll_reset, 1);
        @(negedge clk);
        chk("loss_pll_fall", pll_reset, 0);

        // Timeout on first attempt, lock during the second
        do_reset();
        release_rst(t0);
        wait_out(0, 1'b0, 20, "to_pll_fall");
        wait_out(0, 1'b1, 100, "to_pll_rise");
        chk("to_retry_time", cyc - t0, 54);
        chk("to_retry_count", retry_count, 1);
        wait_out(0, 1'b0, 20, "to_pll_fall2");
        locked = 1'b1;
        chk("to_retry_held", retry_count, 1);
        wait_out(1, 1'b1, 100, "to_sys_rise");
        chk("to_release_time", cyc - t0, 69);
        chk("to_retry_clear", retry_count, 0);

        // Exhaustion: never lock
        do_reset();
        locked = 1'b0;
        release_rst(t0);
        wait_out(2, 1'b1, 400, "ex_fail");
        chk("ex_fail_time", cyc - t0, 162);
        chk("ex_pll_reset", pll_reset, 1);
        chk("ex_sys_rst_n", sys_rst_n, 0);
        chk("ex_retry", retry_count, 2);
        for (int i = 0; i < 30; i++) begin
            locked = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("ex_fail_sticky", fail, 1);

        // Glitch in STABLE
        do_reset();
        locked = 1'b0;
        release_rst(t0);
        wait_out(0, 1'b0, 20, "gl_pll_fall");
        repeat (5) @(negedge clk);
        locked = 1'b1;
        repeat (5) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        wait_out(1, 1'b1, 100, "gl_sys_rise");
        chk("gl_release_time", cyc - t0, 26);
        chk("gl_retry", retry_count, 0);

        // Reset mid-STABLE, then restart
        do_reset();
        locked = 1'b0;
        release_rst(t0);
        wait_out(0, 1'b0, 20, "mr_pll_fall");
        locked = 1'b1;
        repeat (6) @(negedge clk);
        do_reset();
        release_rst(t0);
        wait_out(0, 1'b0, 20, "mr_pll_fall2");
        chk("mr_pll_high_cycles", cyc - t0, 4);
        wait_out(1, 1'b1, 100, "mr_sys_rise");
        chk("mr_release_time", cyc - t0, 13);

        // Randomized lock behaviour with occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            locked = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 90);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
            repeat (len) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock sequencer for the clocking PLL. Drives the PLL's active-high reset, waits for `locked`, requires lock to stay stable for a programmable window, then releases the active-low reset for all downstream logic (DDR3 controller, PHY, and the application side). It runs on the free-running board input clock, which is also the PLL input clock, so it keeps operating while PLL outputs are absent. It detects loss of lock, re-runs the PLL reset sequence, and gives up after a bounded number of retries.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `o_pll_reset` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 200000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 200 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `MAX_RETRIES`, 3: extra reset attempts after the first before entering FAIL.
- `i_clk` input 1: free-running reference clock, the same net that feeds the PLL input.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_locked` input 1: PLL `locked`, asynchronous to `i_clk`.
- `o_pll_reset` output 1: to the PLL reset input, active high.
- `o_sys_rst_n` output 1: downstream reset, active low; high only in RUN.
- `o_lock_lost` output 1: one-cycle pulse on lock loss while in RUN.
- `o_fail` output 1: sticky; retries are exhausted.
- `o_retry_count` output $clog2(MAX_RETRIES+1): number of failed attempts in the current bring-up.
- `o_loss_count` output 8: saturating count of lock-loss events (see Configuration).

## Operation
- `i_locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- All outputs are registered.
- Reset values (during `i_rst_n`=0 and on the first cycle after):
  - `o_pll_reset`=1, `o_sys_rst_n`=0, `o_lock_lost`=0, `o_fail`=0
  - `o_retry_count`=0, `o_loss_count`=0
  - state RESET_PLL, counter 0
- RESET_PLL:
  - `o_pll_reset`=1, `o_sys_rst_n`=0.
  - The counter runs 0..PLL_RST_CYCLES-1, then the FSM goes to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - `o_pll_reset`=0.
  - `locked_s`=1: go to STABLE with the counter cleared.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 without lock:
    - `o_retry_count`==MAX_RETRIES: go to FAIL.
    - Otherwise increment `o_retry_count` and go to RESET_PLL.
  - If lock arrives on the timeout cycle, lock wins.
- STABLE:
  - `locked_s`=0: go back to WAIT_LOCK with the counter cleared. `o_retry_count` is unchanged because this is a glitch, not a timeout.
  - Counter reaches STABLE_CYCLES-1 with `locked_s`=1: go to RUN and clear `o_retry_count`.
- RUN:
  - `o_sys_rst_n`=1.
  - `locked_s`=0: go to RESET_PLL. On the next edge `o_sys_rst_n`=0 and `o_lock_lost` pulses for exactly 1 cycle.
- FAIL:
  - `o_pll_reset`=1, `o_sys_rst_n`=0, `o_fail`=1.
  - Terminal; the only exit is `i_rst_n`.
- `i_rst_n` asserted in any state, mid-count included, returns everything to the reset values on the next edge.
- Counter width is $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES and STABLE_CYCLES. It never wraps: it is cleared on every state change.

## Timing
- `i_locked` to `locked_s`: 2 cycles.
- Cycles from `i_rst_n` release to `o_sys_rst_n` rising, when the PLL locks L cycles after `o_pll_reset` falls and no glitches occur: PLL_RST_CYCLES + L + 2 + STABLE_CYCLES + 1.
- Falling edge of `locked_s` in RUN to `o_sys_rst_n`=0: 1 cycle. `o_pll_reset` rises on the same edge.
- `o_pll_reset` minimum high time is PLL_RST_CYCLES cycles per attempt.

## Configuration
- `PLL_SUPERVISOR_LOSS_COUNTER_EN` defined:
  - `o_loss_count` increments on each `o_lock_lost` pulse.
  - It saturates at 255 and clears only on `i_rst_n`.
- Macro not defined:
  - The counter logic is not built and `o_loss_count` is tied to 0.
  - The port is always present so that instantiations do not change.

## Structure
- Package `pll_supervisor_pkg` holds:
  - the state encoding (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL)
  - the default parameter constants
  - the counter-width function
- Sub-module `sync_2ff`: a generic 2-flop synchronizer, reused by the other clock-domain crossings in the codebase.
- The FSM, counter and output registers live in the top module.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean bring-up: raise `i_locked` 10 cycles after `o_pll_reset` falls -> `o_pll_reset` is high 4 cycles after reset release; `o_sys_rst_n` rises exactly 4+10+2+8+1=25 cycles after release; `o_retry_count`=0.
- Timeout with retry: hold `i_locked`=0 for the first attempt, raise it during the second -> `o_pll_reset` re-pulses for 4 cycles after 50 WAIT_LOCK cycles; `o_retry_count`=1 until RUN, then 0.
- Exhaustion: hold `i_locked`=0 forever -> 3 reset pulses; after the third timeout `o_fail`=1, `o_pll_reset`=1 and `o_sys_rst_n`=0, held until `i_rst_n`.
- Glitch in STABLE: drop `i_locked` for 1 cycle 3 cycles into STABLE -> return to WAIT_LOCK; `o_retry_count` unchanged; release occurs 8 stable cycles after relock.
- Loss in RUN: drop `i_locked` -> 2+1 cycles later `o_sys_rst_n`=0 and `o_lock_lost` is a 1-cycle pulse; a 4-cycle `o_pll_reset` follows. With the macro defined, `o_loss_count`=1; without it, `o_loss_count`=0.
- Reset mid-sequence: assert `i_rst_n`=0 during STABLE -> all outputs at reset values on the next edge; after release, the sequence restarts from RESET_PLL.
